framebuffer_arbiter: RTL and testbench

Arbiter and sequencer that shares the single-port synchronous frame-buffer RAM (`RAM_sync`, 20-bit address, 12-bit RGB) between three users: the VGA scan-out reader, a pixel-write port for the drawing logic, and a built-in clear engine that fills the visible frame with one colour. It sits between the h/v counters plus drawing logic and the RAM instance. It owns the RAM's `addr`, `din` and `we` pins exclusively.

---
 rtl/framebuffer_arbiter.sv | 163 ++++++++++++++++
 tb/tb_framebuffer_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_arbiter.sv
// Frame-buffer RAM arbiter: shares one single-port synchronous RAM between
// the display reader (highest priority), a full-frame clear engine and a
// pixel writer. RAM address/data/write-enable are driven combinationally so
// the display sees the RAM's one-cycle read latency unchanged.
module framebuffer_arbiter #(
  parameter int A     = 20,
  parameter int D     = 12,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic         clk_d,
  input  logic         rst,
  input  logic         disp_req,
  input  logic [9:0]   disp_x,
  input  logic [9:0]   disp_y,
  output logic         disp_valid,
  output logic [D-1:0] disp_data,
  input  logic         wr_req,
  input  logic [9:0]   wr_x,
  input  logic [9:0]   wr_y,
  input  logic [D-1:0] wr_data,
  output logic         wr_ack,
  output logic         wr_drop,
  input  logic         clr_start,
  input  logic [D-1:0] clr_color,
  output logic         clr_busy,
  output logic         clr_done,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout
);

  localparam logic [9:0] H_MAX  = 10'(H_RES);
  localparam logic [9:0] V_MAX  = 10'(V_RES);
  localparam logic [9:0] H_LAST = 10'(H_RES - 1);
  localparam logic [9:0] V_LAST = 10'(V_RES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [9:0]   cx_q, cx_d;
  logic [9:0]   cy_q, cy_d;
  logic [D-1:0] color_q, color_d;
  logic [A-1:0] addr_q, addr_d;
  logic [D-1:0] din_q, din_d;
  logic         clr_done_q, clr_done_d;
  logic         disp_vld_q;
  logic         disp_inr_q;

  logic         disp_inr;
  logic         wr_inr;
  logic         disp_grant;

  assign disp_inr = (disp_x < H_MAX) && (disp_y < V_MAX);
  assign wr_inr   = (wr_x < H_MAX) && (wr_y < V_MAX);

  // Register state, clear counters/colour, the held RAM bus and read-side flags.
  always_ff @(posedge clk_d) begin
    if (rst) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      color_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      clr_done_q <= 1'b0;
      disp_vld_q <= 1'b0;
      disp_inr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      color_q    <= color_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      clr_done_q <= clr_done_d;
      disp_vld_q <= disp_req;
      disp_inr_q <= disp_req && disp_inr;
    end
  end

  // Arbitrate the RAM slot and compute the FSM/counter next state.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    color_d    = color_q;
    addr_d     = addr_q;
    din_d      = din_q;
    clr_done_d = 1'b0;
    ram_we     = 1'b0;
    wr_ack     = 1'b0;
    wr_drop    = 1'b0;
    disp_grant = disp_req && disp_inr;

    if (disp_grant) begin
      // Display read; write data bus keeps its last value.
      addr_d = A'({disp_y, disp_x});
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_req) begin
            wr_ack = 1'b1;
            if (wr_inr) begin
              addr_d = A'({wr_y, wr_x});
              din_d  = wr_data;
              ram_we = 1'b1;
            end else begin
              // Off-screen pixel: acknowledge and discard, slot stays idle.
              wr_drop = 1'b1;
            end
          end
        end
        CLEAR: begin
          addr_d = A'({cy_q, cx_q});
          din_d  = color_q;
          ram_we = 1'b1;
          if (cx_q == H_LAST) begin
            cx_d = '0;
            if (cy_q == V_LAST) begin
              cy_d       = '0;
              state_d    = IDLE;
              clr_done_d = 1'b1;
            end else begin
              cy_d = cy_q + 10'd1;
            end
          end else begin
            cx_d = cx_q + 10'd1;
          end
        end
        default: ;
      endcase
    end

    // A start while idle takes effect next cycle; the writer is still served now.
    if ((state_q == IDLE) && clr_start) begin
      state_d = CLEAR;
      cx_d    = '0;
      cy_d    = '0;
      color_d = clr_color;
    end

    if (rst) begin
      addr_d  = '0;
      din_d   = '0;
      ram_we  = 1'b0;
      wr_ack  = 1'b0;
      wr_drop = 1'b0;
    end
  end

  assign ram_addr   = addr_d;
  assign ram_din    = din_d;
  assign clr_busy   = (state_q == CLEAR);
  assign clr_done   = clr_done_q;
  assign disp_valid = disp_vld_q;
  assign disp_data  = (disp_vld_q && disp_inr_q) ? ram_dout : '0;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter on a 4x3 frame with a behavioural RAM and a
// pixel-image reference model.
module tb_framebuffer_arbiter;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk_d = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [9:0]  disp_x, disp_y;
  logic        disp_valid;
  logic [11:0] disp_data;
  logic        wr_req;
  logic [9:0]  wr_x, wr_y;
  logic [11:0] wr_data;
  logic        wr_ack, wr_drop;
  logic        clr_start;
  logic [11:0] clr_color;
  logic        clr_busy, clr_done;
  logic [19:0] ram_addr;
  logic [11:0] ram_din;
  logic        ram_we;
  logic [11:0] ram_dout;

  framebuffer_arbiter #(.A(20), .D(12), .H_RES(H), .V_RES(V)) dut (
    .clk_d(clk_d), .rst(rst),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_drop(wr_drop),
    .clr_start(clr_start), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk_d = ~clk_d;

  // Single-port synchronous RAM, one-cycle read latency.
  bit [11:0] mem [0:(1<<20)-1];
  always @(posedge clk_d) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] addr_of(input int x, input int y);
    return 20'(y * 1024 + x);
  endfunction

  // Reference model state: expected frame image plus clear progress.
  logic [11:0] img [H][V];
  bit          m_known = 0;
  bit          m_busy, m_done, m_pv, m_pinr, m_ack;
  int          m_k;
  logic [11:0] m_col, m_pdata;
  logic [19:0] m_last_addr;
  logic [11:0] m_last_din;

  task automatic step(input bit r, input bit dq, input int dx, input int dy,
                      input bit wq, input int wx, input int wy, input logic [11:0] wd,
                      input bit cs, input logic [11:0] cc);
    bit          dg, e_we, e_drop, busy_old;
    int          ex, ey;
    logic [19:0] e_addr;
    logic [11:0] e_din;
    @(negedge clk_d);
    rst = r; disp_req = dq; disp_x = 10'(dx); disp_y = 10'(dy);
    wr_req = wq; wr_x = 10'(wx); wr_y = 10'(wy); wr_data = wd;
    clr_start = cs; clr_color = cc;
    #2;
    if (m_known) begin
      chk("disp_valid", 32'(disp_valid), 32'(m_pv));
      chk("disp_data", 32'(disp_data), (m_pv && m_pinr) ? 32'(m_pdata) : 32'd0);
      chk("clr_busy", 32'(clr_busy), 32'(m_busy));
      chk("clr_done", 32'(clr_done), 32'(m_done));
    end
    dg = !r && dq && dx < H && dy < V;
    e_we = 0; m_ack = 0; e_drop = 0; ex = 0; ey = 0;
    e_addr = m_last_addr; e_din = m_last_din;
    if (r) begin
      e_addr = '0; e_din = '0;
    end else if (dg) begin
      e_addr = addr_of(dx, dy);
    end else if (m_busy) begin
      ex = m_k % H; ey = m_k / H;
      e_we = 1; e_addr = addr_of(ex, ey); e_din = m_col;
    end else if (wq) begin
      m_ack = 1;
      if (wx < H && wy < V) begin
        ex = wx; ey = wy; e_we = 1; e_addr = addr_of(wx, wy); e_din = wd;
      end else e_drop = 1;
    end
    chk("wr_ack", 32'(wr_ack), 32'(m_ack));
    chk("wr_drop", 32'(wr_drop), 32'(e_drop));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    if (m_known || r) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    if ((m_known && !dg) || r) chk("ram_din", 32'(ram_din), 32'(e_din));
    // advance the model to the next cycle
    if (r) begin
      m_pv = 0; m_pinr = 0; m_busy = 0; m_done = 0; m_k = 0; m_col = '0;
      m_last_addr = '0; m_last_din = '0; m_known = 1;
    end else begin
      busy_old = m_busy;
      m_pv = dq; m_pinr = dg;
      if (dg) m_pdata = img[dx][dy];
      m_done = 0;
      if (e_we) begin
        img[ex][ey] = e_din;
        m_last_din = e_din;
      end
      if (dg || e_we) m_last_addr = e_addr;
      if (busy_old && !dg) begin
        if (m_k == H * V - 1) begin
          m_busy = 0; m_done = 1; m_k = 0;
        end else m_k++;
      end
      if (cs && !busy_old) begin
        m_busy = 1; m_k = 0; m_col = cc;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 12'h0, 0, 12'h0);
  endtask

  task automatic rd(input int x, input int y);
    step(0, 1, x, y, 0, 0, 0, 12'h0, 0, 12'h0);
  endtask

  initial begin
    int nw, nb, na, cyc;
    bit seen, w_act;
    int wx, wy;
    logic [11:0] wd;
    for (int x = 0; x < H; x++) for (int y = 0; y < V; y++) img[x][y] = '0;

    // Reset with every request high
    step(1, 1, 0, 0, 1, 1, 1, 12'h111, 1, 12'h222);
    step(1, 1, 0, 0, 1, 1, 1, 12'h111, 1, 12'h222);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    rd(0, 0);
    rd(1, 0);
    chk("post_rst_valid", 32'(disp_valid), 32'd1);
    idle();

    // Write then read
    step(0, 0, 0, 0, 1, 2, 1, 12'hABC, 0, 12'h0);
    chk("wr_addr", 32'(ram_addr), 32'h00402);
    chk("wr_we", 32'(ram_we), 32'd1);
    rd(2, 1);
    idle();
    chk("rd_data", 32'(disp_data), 32'hABC);

    // Conflict: display wins for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 1, 3, 2, 12'h123, 0, 12'h0);
      chk("conflict_stall", 32'(wr_ack), 32'd0);
    end
    step(0, 0, 0, 0, 1, 3, 2, 12'h123, 0, 12'h0);
    chk("conflict_ack", 32'(wr_ack), 32'd1);

    // Out of range
    step(0, 0, 0, 0, 1, 4, 0, 12'h777, 0, 12'h0);
    chk("oor_drop", 32'(wr_drop), 32'd1);
    rd(0, 3);
    idle();
    chk("oor_valid", 32'(disp_valid), 32'd1);
    chk("oor_data", 32'(disp_data), 32'd0);

    // Clear without display traffic
    step(0, 0, 0, 0, 0, 0, 0, 12'h0, 1, 12'h0F0);
    nw = 0; nb = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      idle();
      if (clr_done) seen = 1;
      if (clr_busy) nb++;
      if (ram_we) begin
        chk("clr_order", 32'(ram_addr), 32'(addr_of(nw % H, nw / H)));
        nw++;
      end
    end
    chk("clr_seen", 32'(seen), 32'd1);
    chk("clr_writes", 32'(nw), 32'd12);
    chk("clr_cycles", 32'(nb), 32'd12);
    for (int i = 0; i <= H * V; i++) begin
      if (i < H * V) rd(i % H, i / H); else idle();
      if (i > 0) chk("clr_pix", 32'(disp_data), 32'h0F0);
    end

    // Clear with display on alternate cycles
    step(0, 0, 0, 0, 0, 0, 0, 12'h0, 1, 12'h00F);
    nw = 0; nb = 0; seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (i % 2 == 0) rd(i % H, 0); else idle();
      if (clr_done) seen = 1;
      if (clr_busy) nb++;
      if (ram_we) begin
        chk("clr2_order", 32'(ram_addr), 32'(addr_of(nw % H, nw / H)));
        nw++;
      end
    end
    chk("clr2_seen", 32'(seen), 32'd1);
    chk("clr2_writes", 32'(nw), 32'd12);
    chk("clr2_cycles", 32'(nb), 32'd24);

    // Writer and second start during clear
    step(0, 0, 0, 0, 0, 0, 0, 12'h0, 1, 12'h0AA);
    na = 0; seen = 0; cyc = 0;
    while (!seen && cyc < 60) begin
      step(0, 0, 0, 0, 1, 1, 0, 12'h555, cyc == 3, 12'hFFF);
      if (clr_done) seen = 1;
      else if (wr_ack) na++;
      cyc++;
    end
    chk("clr3_seen", 32'(seen), 32'd1);
    chk("clr3_early_ack", 32'(na), 32'd0);
    chk("clr3_done_ack", 32'(wr_ack), 32'd1);
    rd(3, 2);
    rd(1, 0);
    chk("clr3_color", 32'(disp_data), 32'h0AA);
    idle();
    chk("clr3_wr", 32'(disp_data), 32'h555);

    // Reset mid-clear
    step(0, 0, 0, 0, 0, 0, 0, 12'h0, 1, 12'h321);
    for (int i = 0; i < 5; i++) idle();
    step(1, 0, 0, 0, 0, 0, 0, 12'h0, 0, 12'h0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (clr_busy || clr_done) nb++;
    end
    chk("rst_abort", 32'(nb), 32'd0);

    // Randomized traffic against the model
    w_act = 0; wx = 0; wy = 0; wd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!w_act && $urandom_range(0, 2) == 0) begin
        w_act = 1; wx = $urandom_range(0, 4); wy = $urandom_range(0, 3);
        wd = 12'($urandom);
      end
      step($urandom_range(0, 399) == 0, 1'($urandom), $urandom_range(0, 4),
           $urandom_range(0, 3), w_act, wx, wy, wd,
           $urandom_range(0, 39) == 0, 12'($urandom));
      if (m_ack) w_act = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
